// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types, timing presets and phase helper for the DVI timing generator
package dvi_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } dvi_state_e;

    typedef logic [11:0] coord_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } dvi_timing_t;

    localparam dvi_timing_t DVI_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam dvi_timing_t DVI_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    // Phase stepping shared by the horizontal and vertical FSMs: leave a phase on its last count.
    function automatic dvi_state_e phase_next(
        input dvi_state_e cur,
        input coord_t     cnt,
        input coord_t     act_end,
        input coord_t     fp_end,
        input coord_t     sync_end,
        input coord_t     last
    );
        phase_next = cur;
        case (cur)
            ACTIVE: if (cnt == act_end)  phase_next = FP;
            FP:     if (cnt == fp_end)   phase_next = SYNC;
            SYNC:   if (cnt == sync_end) phase_next = BP;
            BP:     if (cnt == last)     phase_next = ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/dvi_ctrl_delay.sv
// rtl/dvi_ctrl_delay.sv - depth-N enabled 3-bit shift register; N=0 is a pass-through
module dvi_ctrl_delay #(
    parameter int         N       = 2,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    if (N == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, reset_i, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [2:0] stage_q [N];

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[N-1];
    end

endmodule

// File: rtl/dvi_timing_gen.sv
// rtl/dvi_timing_gen.sv - DVI raster timing generator (de/hsync/vsync, line/frame pulses)
// Define DVI_TIMING_COORD_EN to add the registered x/y coordinate outputs.
module dvi_timing_gen
    import dvi_pkg::*;
#(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   CTRL_DELAY = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output logic   de,
    output logic   hsync,
    output logic   vsync,
    output logic   frame_start,
    output logic   line_start
`ifdef DVI_TIMING_COORD_EN
    ,
    output coord_t x,
    output coord_t y
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE - 1);
    localparam coord_t H_FP_END   = coord_t'(H_ACTIVE + H_FP - 1);
    localparam coord_t H_SYNC_END = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE - 1);
    localparam coord_t V_FP_END   = coord_t'(V_ACTIVE + V_FP - 1);
    localparam coord_t V_SYNC_END = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);

    localparam logic [2:0] CTRL_IDLE = {1'b0, ~HS_POL, ~VS_POL};

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
        $error("dvi_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_phase_check
        $error("dvi_timing_gen: every timing phase must be at least one unit long");
    end
    if (CTRL_DELAY < 0 || CTRL_DELAY > 7) begin : g_delay_check
        $error("dvi_timing_gen: CTRL_DELAY must be in 0..7");
    end

    coord_t     h_cnt_q, h_cnt_d;
    coord_t     v_cnt_q, v_cnt_d;
    dvi_state_e hstate_q, hstate_d;
    dvi_state_e vstate_q, vstate_d;
    logic       h_wrap;
    logic       de_raw, hs_raw, vs_raw;
    logic       frame_start_q, line_start_q;
    logic [2:0] ctrl_q, ctrl_dly;

    assign h_wrap = (h_cnt_q == H_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            hstate_q <= ACTIVE;
            vstate_q <= ACTIVE;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            hstate_q <= hstate_d;
            vstate_q <= vstate_d;
        end
    end

    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        hstate_d = hstate_q;
        vstate_d = vstate_q;
        if (en) begin
            h_cnt_d  = h_wrap ? '0 : h_cnt_q + 12'd1;
            hstate_d = phase_next(hstate_q, h_cnt_q, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST);
            if (h_wrap) begin
                v_cnt_d  = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
                vstate_d = phase_next(vstate_q, v_cnt_q, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST);
            end
        end
    end

    always_comb begin
        de_raw = (hstate_q == ACTIVE) && (vstate_q == ACTIVE);
        hs_raw = (hstate_q == SYNC) ? HS_POL : ~HS_POL;
        vs_raw = (vstate_q == SYNC) ? VS_POL : ~VS_POL;
    end

    // Pulses are cleared on idle cycles so each marks exactly one enabled pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            ctrl_q        <= CTRL_IDLE;
        end else begin
            frame_start_q <= en && (h_cnt_q == '0) && (v_cnt_q == '0);
            line_start_q  <= en && (h_cnt_q == '0);
            if (en) ctrl_q <= {de_raw, hs_raw, vs_raw};
        end
    end

`ifdef DVI_TIMING_COORD_EN
    coord_t x_q, y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= h_cnt_q;
            y_q <= v_cnt_q;
        end
    end

    assign x = x_q;
    assign y = y_q;
`endif

    dvi_ctrl_delay #(
        .N       (CTRL_DELAY),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_delay (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (en),
        .d_i     (ctrl_q),
        .q_o     (ctrl_dly)
    );

    assign {de, hsync, vsync} = ctrl_dly;
    assign frame_start        = frame_start_q;
    assign line_start         = line_start_q;

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- CTRL_DELAY, 2, extra enabled cycles applied to de/hsync/vsync over x/y, in the range 0..7.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- en, in, 1, pixel-advance enable.
- de, out, 1, data enable.
- hsync, out, 1, horizontal sync, drives encoder C0 on channel 0.
- vsync, out, 1, vertical sync, drives encoder C1 on channel 0.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- line_start, out, 1, one-cycle pulse at x=0 of every line.
- x, out, 12, horizontal position.
- y, out, 12, vertical position.

Function
REQ-003 Totals SHALL be fixed: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Each total SHALL be at most 4096; a violation is an elaboration error.
REQ-004 The horizontal counter h_cnt (12 bit) SHALL increment on each clk edge with en=1.
- It SHALL wrap from H_TOTAL-1 to 0.
REQ-005 The vertical counter v_cnt (12 bit) SHALL increment only on the h_cnt wrap.
- It SHALL wrap from V_TOTAL-1 to 0.
- A simultaneous h and v wrap SHALL give (0,0).
REQ-006 A horizontal FSM SHALL track the states ACTIVE, FP, SYNC and BP.
- ACTIVE to FP at h_cnt=H_ACTIVE-1.
- FP to SYNC at H_ACTIVE+H_FP-1.
- SYNC to BP at H_ACTIVE+H_FP+H_SYNC-1.
- BP to ACTIVE at H_TOTAL-1.
- The vertical FSM SHALL use the same states on v_cnt boundaries and SHALL step only at the h_cnt wrap.
REQ-007 The raw control signals SHALL be defined as follows.
- de_raw = (hstate==ACTIVE && vstate==ACTIVE).
- hs_raw = (hstate==SYNC) ? HS_POL : ~HS_POL.
- vs_raw = (vstate==SYNC) ? VS_POL : ~VS_POL.
REQ-008 x, y, frame_start and line_start SHALL be registered from the counter value before its advance, giving one-cycle latency.
REQ-009 de, hsync and vsync SHALL pass through a CTRL_DELAY-stage enabled shift register after the same one-cycle register.
- They therefore lag x/y by exactly CTRL_DELAY enabled cycles, which lets encoder data lead control.
REQ-010 With en=0, all counters, FSMs, delay stages and outputs SHALL hold, and frame_start/line_start SHALL be forced to 0.

Reset
REQ-011 Asserting reset SHALL immediately clear the counters and FSMs to (0, ACTIVE).
- Outputs SHALL go to de=0, hsync=~HS_POL, vsync=~VS_POL, x=0, y=0, frame_start=0, line_start=0.
- All delay stages SHALL be filled with the inactive levels.
REQ-012 The first enabled edge after reset release SHALL produce x=0, y=0, frame_start=1 and line_start=1.
- de SHALL rise CTRL_DELAY enabled edges later.
REQ-013 Reset mid-frame SHALL abandon the frame; no partial sync pulse SHALL be extended past reset.

Configuration
REQ-014 With DVI_TIMING_COORD_EN defined, ports x and y SHALL exist and be driven per REQ-008.
REQ-015 Without DVI_TIMING_COORD_EN, ports x and y and their registers SHALL be omitted.
- All other behaviour SHALL be unchanged.

Structure
REQ-016 Package dvi_pkg SHALL hold the following shared items.
- The state enum typedef (ACTIVE, FP, SYNC, BP).
- The 12-bit coordinate typedef.
- Timing constant sets for 640x480@60 and 800x600@60.
REQ-017 The delay of REQ-009 SHALL be a sub-module dvi_ctrl_delay.
- It SHALL be a parametrised depth-N, 3-bit-wide enabled shift register with reset load value.
- N=0 SHALL be a pass-through.

Verification
REQ-018 Defaults, en=1, two frames: check the following.
- de is high 640 cycles per line.
- hsync is low for 96 cycles starting 656 cycles after line_start.
- vsync is low on lines 490-491.
- frame_start period is 420000 cycles.
REQ-019 CTRL_DELAY=2: check that de rises exactly 2 cycles after the x=0,y=0 frame_start cycle, and falls 2 cycles after x=639.
REQ-020 Small parameters H=4/1/2/1, V=3/1/1/1, CTRL_DELAY=0: check the following.
- H_TOTAL=8 and V_TOTAL=6.
- The full state sequence and wrap (7,5) to (0,0) with frame_start=1.
REQ-021 en pseudo-random at 50% duty: enabled-cycle counts SHALL match REQ-018.
- All outputs SHALL be stable during en=0 cycles.
REQ-022 Reset asserted at x=700,y=100 during hsync: check the following.
- hsync returns to inactive asynchronously.
- After release, the first enabled edge gives x=0, y=0, frame_start=1.
REQ-023 HS_POL=1, VS_POL=1: check that the sync pulses are high with identical timing, and that the reset levels are 0.
